product_accumulator: RTL and testbench

//  Downstream stage of the combinational signed multiplier. Consumes a burst of
//  2*WIDTH-bit two's-complement products and their overflow flag over a

---
 rtl/product_accumulator.sv | 140 ++++++++++++++
 tb/tb_product_accumulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a burst of signed 2*WIDTH-bit products from the multiplier into a
//   saturating ACC_WIDTH accumulator. It presents one result per burst, with
//   sticky saturation and overflow flags.
//
// Ports
//   clk_in            clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   start_in          begin a burst (sampled only in IDLE)
//   length_in         products in the burst, sampled with start_in
//   clear_in          synchronous abort back to IDLE, highest priority
//   product_in        signed product from the multiplier
//   overflow_in       multiplier overflow flag, qualified by a product transfer
//   product_valid_in  product_in / overflow_in valid
//   product_ready_out accumulator accepts a product this cycle (ACCUM)
//   result_out        signed accumulated sum
//   result_valid_out  result_out and flags valid (HOLD)
//   result_ready_in   consumer accepts the result
//   sat_out           sticky: accumulator clamped during this burst
//   ovf_out           sticky: overflow_in seen on an accepted product
//   busy_out          high in ACCUM or HOLD
module product_accumulator #(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 2*WIDTH+8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start_in,
    input  logic [COUNT_WIDTH-1:0]      length_in,
    input  logic                        clear_in,
    input  logic signed [2*WIDTH-1:0]   product_in,
    input  logic                        overflow_in,
    input  logic                        product_valid_in,
    output logic                        product_ready_out,
    output logic signed [ACC_WIDTH-1:0] result_out,
    output logic                        result_valid_out,
    input  logic                        result_ready_in,
    output logic                        sat_out,
    output logic                        ovf_out,
    output logic                        busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0]      COUNT_ONE = COUNT_WIDTH'(1);

    state_t                        state;
    state_t                        state_next;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0]        count;
    logic                          sat;
    logic                          ovf;
    logic signed [ACC_WIDTH:0]     sum_wide;
    logic                          transfer;

    // The top two bits of the one-bit-wider sum disagree exactly when the
    // true sum no longer fits in ACC_WIDTH bits.
    function automatic logic sat_hit(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] != s[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_value(input logic signed [ACC_WIDTH:0] s);
        if (sat_hit(s)) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    assign sum_wide = {acc[ACC_WIDTH-1], acc}
                    + {{(ACC_WIDTH+1-2*WIDTH){product_in[2*WIDTH-1]}}, product_in};

    // clear_in blocks a product offered in the same cycle.
    assign transfer = (state == ACCUM) && product_valid_in && !clear_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_in) state_next = (length_in != '0) ? ACCUM : HOLD;
                ACCUM:   if (transfer && count == COUNT_ONE) state_next = HOLD;
                HOLD:    if (result_ready_in) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        product_ready_out = (state == ACCUM);
        result_valid_out  = (state == HOLD);
        busy_out          = (state == ACCUM) || (state == HOLD);
    end

    // Accumulator datapath. A zero-length start also clears acc and flags, so
    // the HOLD that follows presents a clean zero result.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear_in) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start_in) begin
            acc   <= '0;
            count <= length_in;
            sat   <= 1'b0;
            ovf   <= 1'b0;
        end else if (transfer) begin
            acc   <= sat_value(sum_wide);
            count <= count - COUNT_ONE;
            sat   <= sat | sat_hit(sum_wide);
            ovf   <= ovf | overflow_in;
        end
    end

    assign result_out = acc;
    assign sat_out    = sat;
    assign ovf_out    = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  length = 8'd0;
    logic        clear = 1'b0;
    logic [31:0] product = 32'd0;
    logic        overflow = 1'b0;
    logic        pvalid = 1'b0;
    logic        rready = 1'b0;

    logic        pready_a, rvalid_a, sat_a, ovf_a, busy_a;
    logic [39:0] res_a;
    logic        pready_b, rvalid_b, sat_b, ovf_b, busy_b;
    logic [32:0] res_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .COUNT_WIDTH(8)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .length_in(length),
        .clear_in(clear), .product_in(product), .overflow_in(overflow),
        .product_valid_in(pvalid), .product_ready_out(pready_a),
        .result_out(res_a), .result_valid_out(rvalid_a), .result_ready_in(rready),
        .sat_out(sat_a), .ovf_out(ovf_a), .busy_out(busy_a)
    );

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .COUNT_WIDTH(8)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .length_in(length),
        .clear_in(clear), .product_in(product), .overflow_in(overflow),
        .product_valid_in(pvalid), .product_ready_out(pready_b),
        .result_out(res_b), .result_valid_out(rvalid_b), .result_ready_in(rready),
        .sat_out(sat_b), .ovf_out(ovf_b), .busy_out(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic push(input logic [31:0] p, input logic ov);
        pvalid   = 1'b1;
        product  = p;
        overflow = ov;
        tick();
        pvalid   = 1'b0;
        overflow = 1'b0;
    endtask

    task automatic accept();
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++; if ({pready_a, rvalid_a, sat_a, ovf_a, busy_a} !== 5'b0) begin
            mismatched++; $display("FAIL reset_ctrl got %b want 00000", {pready_a, rvalid_a, sat_a, ovf_a, busy_a}); end
        compared++; if (res_a !== 40'd0) begin
            mismatched++; $display("FAIL reset_result got %0h want 0", res_a); end
        rst_n = 1'b1;
        tick();
        compared++; if (busy_a !== 1'b0) begin
            mismatched++; $display("FAIL reset_idle_busy got %b want 0", busy_a); end
    endtask

    task automatic test_basic();
        start_burst(8'd3);
        compared++; if ({pready_a, busy_a, rvalid_a} !== 3'b110) begin
            mismatched++; $display("FAIL basic_accum_state got %b want 110", {pready_a, busy_a, rvalid_a}); end
        push(32'd6, 1'b0);
        push(-32'sd2, 1'b0);
        compared++; if (rvalid_a !== 1'b0) begin
            mismatched++; $display("FAIL basic_early_valid got %b want 0", rvalid_a); end
        push(32'd100, 1'b0);
        compared++; if (rvalid_a !== 1'b1) begin
            mismatched++; $display("FAIL basic_valid got %b want 1", rvalid_a); end
        compared++; if (res_a !== 40'd104) begin
            mismatched++; $display("FAIL basic_result got %0d want 104", res_a); end
        compared++; if ({sat_a, ovf_a, pready_a} !== 3'b000) begin
            mismatched++; $display("FAIL basic_flags got %b want 000", {sat_a, ovf_a, pready_a}); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            start = 1'b0;
            compared++; if ({rvalid_a, pready_a, busy_a} !== 3'b101 || res_a !== 40'd104) begin
                mismatched++; $display("FAIL bp_hold_%0d got v/r/b=%b res=%0d want 101 res=104",
                                       i, {rvalid_a, pready_a, busy_a}, res_a); end
        end
        rready = 1'b1;
        start  = 1'b1;
        tick();
        rready = 1'b0;
        start  = 1'b0;
        compared++; if ({rvalid_a, busy_a} !== 2'b00) begin
            mismatched++; $display("FAIL bp_release got %b want 00", {rvalid_a, busy_a}); end
        tick();
        compared++; if ({busy_a, pready_a} !== 2'b00) begin
            mismatched++; $display("FAIL bp_start_ignored got %b want 00", {busy_a, pready_a}); end
    endtask

    task automatic test_saturation();
        start_burst(8'd3);
        repeat (3) push(32'h7FFF_FFFF, 1'b0);
        compared++; if (res_b !== 33'h0_FFFF_FFFF || sat_b !== 1'b1) begin
            mismatched++; $display("FAIL sat_pos got %0h/%b want ffffffff/1", res_b, sat_b); end
        compared++; if (res_a !== 40'h01_7FFF_FFFD || sat_a !== 1'b0) begin
            mismatched++; $display("FAIL sat_pos_wide got %0h/%b want 17ffffffd/0", res_a, sat_a); end
        accept();
        start_burst(8'd3);
        compared++; if (sat_b !== 1'b0 || res_b !== 33'd0) begin
            mismatched++; $display("FAIL sat_cleared_on_start got %b/%0h want 0/0", sat_b, res_b); end
        repeat (2) push(32'h8000_0000, 1'b0);
        compared++; if (res_b !== 33'h1_0000_0000 || sat_b !== 1'b0) begin
            mismatched++; $display("FAIL sat_neg_exact_min got %0h/%b want 100000000/0", res_b, sat_b); end
        push(32'h8000_0000, 1'b0);
        compared++; if (res_b !== 33'h1_0000_0000 || sat_b !== 1'b1 || rvalid_b !== 1'b1) begin
            mismatched++; $display("FAIL sat_neg got %0h/%b/%b want 100000000/1/1", res_b, sat_b, rvalid_b); end
        compared++; if (res_a !== 40'hFE_8000_0000 || sat_a !== 1'b0) begin
            mismatched++; $display("FAIL sat_neg_wide got %0h/%b want fe80000000/0", res_a, sat_a); end
        accept();
    endtask

    task automatic test_zero_length();
        start_burst(8'd0);
        compared++; if ({rvalid_b, busy_b} !== 2'b11 || res_b !== 33'd0 || {sat_b, ovf_b} !== 2'b00) begin
            mismatched++; $display("FAIL zero_len got v/b=%b res=%0h flags=%b want 11 0 00",
                                   {rvalid_b, busy_b}, res_b, {sat_b, ovf_b}); end
        accept();
        start_burst(8'd2);
        push(32'd1, 1'b0);
        compared++; if (ovf_a !== 1'b0) begin
            mismatched++; $display("FAIL ovf_early got %b want 0", ovf_a); end
        push(32'd2, 1'b1);
        compared++; if (ovf_a !== 1'b1 || res_a !== 40'd3 || rvalid_a !== 1'b1) begin
            mismatched++; $display("FAIL ovf_sticky got %b/%0d/%b want 1/3/1", ovf_a, res_a, rvalid_a); end
        accept();
    endtask

    task automatic test_valid_gaps();
        start_burst(8'd4);
        for (int i = 1; i <= 4; i++) begin
            push(32'(i), 1'b0);
            if (i < 4) begin
                tick();
                compared++; if ({rvalid_a, busy_a} !== 2'b01) begin
                    mismatched++; $display("FAIL gap_%0d got %b want 01", i, {rvalid_a, busy_a}); end
            end
        end
        compared++; if (res_a !== 40'd10 || rvalid_a !== 1'b1) begin
            mismatched++; $display("FAIL gap_result got %0d/%b want 10/1", res_a, rvalid_a); end
        accept();
    endtask

    task automatic test_clear();
        start_burst(8'd4);
        push(32'd1, 1'b0);
        push(32'd2, 1'b1);
        clear   = 1'b1;
        pvalid  = 1'b1;
        product = 32'd3;
        tick();
        clear  = 1'b0;
        pvalid = 1'b0;
        compared++; if ({busy_a, rvalid_a, pready_a, ovf_a} !== 4'b0000 || res_a !== 40'd0) begin
            mismatched++; $display("FAIL clear_idle got %b res=%0d want 0000 res=0",
                                   {busy_a, rvalid_a, pready_a, ovf_a}, res_a); end
        repeat (3) begin
            tick();
            compared++; if (rvalid_a !== 1'b0) begin
                mismatched++; $display("FAIL clear_no_valid got %b want 0", rvalid_a); end
        end
    endtask

    task automatic test_reset_mid_burst();
        start_burst(8'd4);
        push(32'd9, 1'b1);
        push(32'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        compared++; if ({pready_a, rvalid_a, sat_a, ovf_a, busy_a} !== 5'b0 || res_a !== 40'd0) begin
            mismatched++; $display("FAIL reset_mid got %b res=%0d want 00000 res=0",
                                   {pready_a, rvalid_a, sat_a, ovf_a, busy_a}, res_a); end
        tick();
        rst_n = 1'b1;
        tick();
        start_burst(8'd2);
        push(32'd5, 1'b0);
        push(32'd7, 1'b0);
        compared++; if (res_a !== 40'd12 || rvalid_a !== 1'b1 || ovf_a !== 1'b0) begin
            mismatched++; $display("FAIL reset_residue got %0d/%b/%b want 12/1/0", res_a, rvalid_a, ovf_a); end
        accept();
        compared++; if (busy_a !== 1'b0) begin
            mismatched++; $display("FAIL reset_final_idle got %b want 0", busy_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_zero_length();
        test_valid_gaps();
        test_clear();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
